// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: widths, opcodes, field positions, decode bundle
// Contents: XLEN/NREG_W, OP_* opcodes, instruction field bit positions,
//           dec_t decode bundle, sign-extension helpers.
package cpu_pkg;

  localparam int XLEN   = 16;
  localparam int NREG_W = 3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Register fields: A=[11:9], B=[8:6], C=[5:3]
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RA_MSB = 11;
  localparam int RA_LSB = 9;
  localparam int RB_MSB = 8;
  localparam int RB_LSB = 6;
  localparam int RC_MSB = 5;
  localparam int RC_LSB = 3;

  typedef struct packed {
    logic [NREG_W-1:0] rd;
    logic [NREG_W-1:0] rs1;
    logic [NREG_W-1:0] rs2;
    logic [XLEN-1:0]   imm;
    logic [3:0]        alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              halt;
    logic              uses_rs1;
    logic              uses_rs2;
  } dec_t;

  function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
    return {{(XLEN-6){v[5]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational instruction decoder
// Ports: instr (in)  instruction word held in the IF/ID register
//        dec   (out) register indices, immediate, ungated control signals,
//                    uses_rs1/uses_rs2 for the hazard unit
module id_decoder (
  input  logic [cpu_pkg::XLEN-1:0] instr,
  output cpu_pkg::dec_t            dec
);
  import cpu_pkg::*;

  logic [3:0] op;
  assign op = instr[OP_MSB:OP_LSB];

  always_comb begin
    dec        = '0;
    dec.alu_op = op;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        dec.rd        = instr[RA_MSB:RA_LSB];
        dec.rs1       = instr[RB_MSB:RB_LSB];
        dec.rs2       = instr[RC_MSB:RC_LSB];
        dec.reg_write = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        dec.rd        = instr[RA_MSB:RA_LSB];
        dec.rs1       = instr[RB_MSB:RB_LSB];
        dec.imm       = sext6(instr[5:0]);
        dec.reg_write = 1'b1;
        dec.mem_read  = (op == OP_LW);
        dec.uses_rs1  = 1'b1;
      end
      OP_SW: begin
        // base comes from field B, store data from field A
        dec.rs1       = instr[RB_MSB:RB_LSB];
        dec.rs2       = instr[RA_MSB:RA_LSB];
        dec.imm       = sext6(instr[5:0]);
        dec.mem_write = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.rs1      = instr[RA_MSB:RA_LSB];
        dec.rs2      = instr[RB_MSB:RB_LSB];
        dec.imm      = sext6(instr[5:0]);
        dec.branch   = 1'b1;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      OP_JMP: begin
        dec.imm  = sext12(instr[11:0]);
        dec.jump = 1'b1;
      end
      OP_LUI: begin
        dec.rd        = instr[RA_MSB:RA_LSB];
        dec.imm       = {instr[8:0], 7'b0};
        dec.reg_write = 1'b1;
      end
      OP_HALT: begin
        dec.halt = 1'b1;
      end
      default: begin
        // NOP: nothing beyond the defaults
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID register, wrong-path kill and load-use hazard unit
// Optional feature macro: ID_STALL_CNT_EN (load-use stall-cycle counter on stall_cnt;
//   without it stall_cnt is tied to 0).
// Ports: clk, rst (async active-low); if_pc/if_instr from fetch and sync imem;
//        branch_taken, ex_valid, ex_mem_read, ex_rd from EX;
//        stall_if to fetch; id_* decoded instruction for EX; stall_cnt.
module id_stage #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int NREG_W = cpu_pkg::NREG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [XLEN-1:0]   if_instr,
  input  logic              branch_taken,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [NREG_W-1:0] ex_rd,
  output logic              stall_if,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output logic [NREG_W-1:0] id_rd,
  output logic [NREG_W-1:0] id_rs1,
  output logic [NREG_W-1:0] id_rs2,
  output logic [XLEN-1:0]   id_imm,
  output logic [3:0]        id_alu_op,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_branch,
  output logic              id_jump,
  output logic              id_halt,
  output logic [15:0]       stall_cnt
);
  import cpu_pkg::*;

  logic [XLEN-1:0] pc_d;      // PC matching the word imem presents this cycle
  logic [XLEN-1:0] ir_instr;
  logic [XLEN-1:0] ir_pc;
  logic            ir_valid;
  logic            kill;      // drop the wrong-path word already inside imem
  dec_t            dec;

  id_decoder u_dec (
    .instr (ir_instr),
    .dec   (dec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_d     <= '0;
      ir_instr <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      kill     <= 1'b0;
    end else begin
      if (!stall_if) pc_d <= if_pc;
      if (branch_taken) begin
        ir_valid <= 1'b0;
        kill     <= 1'b1;
      end else if (!stall_if) begin
        ir_instr <= if_instr;
        ir_pc    <= pc_d;
        ir_valid <= ~kill;
        kill     <= 1'b0;
      end
    end
  end

  logic rs1_hit, rs2_hit;
  assign rs1_hit = dec.uses_rs1 && (dec.rs1 == ex_rd);
  assign rs2_hit = dec.uses_rs2 && (dec.rs2 == ex_rd);

  // A redirect discards the decode word anyway, so it must never stall fetch.
  assign stall_if = ir_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                    && (rs1_hit || rs2_hit) && !branch_taken;
  assign id_valid = ir_valid && !stall_if && !branch_taken;

  assign id_pc        = ir_pc;
  assign id_rd        = dec.rd;
  assign id_rs1       = dec.rs1;
  assign id_rs2       = dec.rs2;
  assign id_imm       = dec.imm;
  assign id_alu_op    = dec.alu_op;
  assign id_reg_write = dec.reg_write && id_valid;
  assign id_mem_read  = dec.mem_read  && id_valid;
  assign id_mem_write = dec.mem_write && id_valid;
  assign id_branch    = dec.branch    && id_valid;
  assign id_jump      = dec.jump      && id_valid;
  assign id_halt      = dec.halt      && id_valid;

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall_if && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of the fetch stage.
- Pairs each word from the synchronous instruction memory with its PC and holds it in the IF/ID register.
- Decodes fields, control signals and the sign-extended immediate.
- Detects load-use hazards and drives the fetch stall.
- Kills wrong-path words after a taken branch.

Parameters:
- XLEN, 16, data/PC/instruction width.
- NREG_W, 3, register index width (8 registers, r0 reads zero).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  16  current fetch PC (address presented to imem this cycle).
- if_instr  in  16  imem output; corresponds to the if_pc of the previous cycle.
- branch_taken  in  1  redirect from EX; flushes the in-flight decode.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_mem_read  in  1  EX instruction is LW.
- ex_rd  in  3  EX destination register.
- stall_if  out  1  hold fetch PC (load-use hazard).
- id_valid  out  1  decode outputs are a live instruction for EX this cycle.
- id_pc  out  16  PC of the decoded instruction.
- id_rd / id_rs1 / id_rs2  out  3 each  register indices.
- id_imm  out  16  immediate, extended per format.
- id_alu_op  out  4  equals the opcode.
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_halt  out  1 each  control signals.
- stall_cnt  out  16  load-use stall-cycle counter (see Optional Feature).

Behaviour:
- Reset: while rst=0, all registered state clears immediately.
  - id_valid=0, id_pc=0, captured instruction=0 (NOP decodes as opcode 0 with id_valid=0), kill=0.
  - All outputs are therefore 0.
- PC alignment: internal pc_d <= if_pc on each edge where stall_if=0, so pc_d pairs with if_instr.
- IF/ID register update each rising edge, with priority: flush > stall > load.
  - flush (branch_taken=1): ir_valid<=0; kill<=1.
  - stall (stall_if=1): ir_* hold.
  - load: ir_instr<=if_instr; ir_pc<=pc_d; ir_valid <= ~kill; kill<=0.
- Flush behaviour: kill drops the one wrong-path word already in flight from imem. Net effect: two bubbles after a taken branch.
- Encoding: op=[15:12].
  - R-type 0-6 (ADD, SUB, AND, OR, XOR, SLL, SRL): rd=[11:9], rs1=[8:6], rs2=[5:3].
  - 7 ADDI and 8 LW: rd=[11:9], rs1=[8:6], imm=sext([5:0]).
  - 9 SW: rs1=[8:6] (base), rs2=[11:9] (data), imm=sext([5:0]).
  - A BEQ, B BNE: rs1=[11:9], rs2=[8:6], imm=sext([5:0]).
  - C JMP: imm=sext([11:0]).
  - D LUI: rd=[11:9], imm={[8:0], 7'b0}.
  - E NOP.
  - F HALT.
- Unused register fields output 0. The uses_rs1/uses_rs2 flags are internal.
- Control signals:
  - reg_write for ops 0-8 and D.
  - mem_read for 8; mem_write for 9; branch for A/B; jump for C; halt for F.
  - All control signals are gated by id_valid.
- Hazard (combinational): stall_if=1 iff all of the following hold:
  - ir_valid, ex_valid, ex_mem_read, ex_rd != 0;
  - and either (uses_rs1 and ex_rd==rs1) or (uses_rs2 and ex_rd==rs2).
- During a stall, id_valid=0 (bubble to EX) and the IF/ID register holds.
  - The next cycle EX no longer holds the LW, so the stall lasts exactly one cycle.
- branch_taken and a hazard in the same cycle: flush wins; stall_if is forced to 0.
- id_valid = ir_valid & ~stall_if & ~branch_taken.
- HALT decoded: id_halt=1 while valid. Halting fetch is not this block's job.

Optional Feature:
- Macro ID_STALL_CNT_EN.
- Defined: stall_cnt increments on every cycle with stall_if=1, saturates at 16'hFFFF, and clears on reset.
- Undefined: the stall_cnt port remains and is tied to 0; no counter flops are synthesized.

Decomposition:
- Shared package (cpu_pkg) holds:
  - opcode localparams OP_ADD..OP_HALT;
  - field bit-position constants;
  - XLEN.
- One sub-module, id_decoder: purely combinational, instruction in -> fields, immediate, control signals and uses_rs1/uses_rs2 out.
- id_stage holds the registers, kill logic and hazard unit.

Test Plan:
- Reset release, imem feeding ADDI r1,r0,-1 (16'h723F) at PC 0 -> one cycle later id_valid=1, id_pc=0, id_rd=1, id_imm=16'hFFFF, id_reg_write=1.
- LW r2,0(r1) then ADD r3,r2,r1, with ex_valid=1, ex_mem_read=1, ex_rd=2 when ADD is in ID -> stall_if=1 and id_valid=0 for exactly 1 cycle; ADD issues with id_pc unchanged; stall_cnt=1 with ID_STALL_CNT_EN.
- Same sequence with ex_rd=0 -> no stall.
- Same sequence with ex_mem_read=0 -> no stall.
- branch_taken pulse for 1 cycle at PC 5 -> id_valid=0 for the next 2 cycles; first valid id_pc equals the branch target.
- branch_taken coincident with a load-use hazard -> stall_if=0, IF/ID flushed, kill set.
- rst asserted mid-stream with id_valid=1 -> all outputs 0 immediately, without a clock edge.
- JMP 16'hC800 -> id_imm=16'hF800, id_jump=1.
- LUI r1,0x1FF -> id_imm=16'hFF80.
